// File: rtl/dg_adc_pkg.sv
// -----------------------------------------------------------------------------
// dg_adc_pkg
// Shared definitions for the SAR ADC controller.
//   - adc_state_e       : controller FSM states (IDLE, SAMPLE, TRIAL, DONE)
//   - DG_ADC_WIDTH_DEF  : default conversion resolution in bits
//   - DG_ADC_SETTLE_DEF : default cycles per sample phase / bit trial
// -----------------------------------------------------------------------------
package dg_adc_pkg;

  localparam int DG_ADC_WIDTH_DEF  = 8;
  localparam int DG_ADC_SETTLE_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_TRIAL  = 2'd2,
    ST_DONE   = 2'd3
  } adc_state_e;

endpackage

// File: rtl/dg_sync2.sv
// -----------------------------------------------------------------------------
// dg_sync2
// Two-flop synchronizer for the asynchronous comparator output.
// Only compiled when DG_ADC_COMP_SYNC_EN is defined; the default build of the
// controller samples the comparator directly and has no use for it.
// Ports:
//   clk   - sampling clock
//   rst_n - asynchronous active-low reset, clears both stages
//   d     - asynchronous input
//   q     - synchronized output (two clock cycles of latency)
// -----------------------------------------------------------------------------
`ifdef DG_ADC_COMP_SYNC_EN
module dg_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule
`endif

// File: rtl/dg_sar_adc_ctrl.sv
// -----------------------------------------------------------------------------
// dg_sar_adc_ctrl
// Successive-approximation ADC controller. Tracks the input for SETTLE cycles,
// then tests one bit per phase from MSB to LSB against the comparator, and
// presents the final code with a valid/ready handshake.
// Optional build macro: DG_ADC_COMP_SYNC_EN -- routes comp through dg_sync2
// and stretches each bit-trial phase to SETTLE+2 cycles to absorb its latency.
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst_n    - asynchronous active-low reset
//   start    - conversion request (taken in IDLE, or in DONE on handshake)
//   comp     - comparator, 1 = analog input >= DAC output
//   dac_code - trial code to the DAC
//   sample   - track/hold control, high = track
//   busy     - high during SAMPLE and TRIAL
//   result   - converted code, stable while valid is high
//   valid    - result available
//   ready    - consumer accepts result
// All outputs are registered.
// -----------------------------------------------------------------------------
module dg_sar_adc_ctrl
  import dg_adc_pkg::*;
#(
  parameter int WIDTH  = DG_ADC_WIDTH_DEF,
  parameter int SETTLE = DG_ADC_SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             comp,
  output logic [WIDTH-1:0] dac_code,
  output logic             sample,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  input  logic             ready
);

`ifdef DG_ADC_COMP_SYNC_EN
  localparam int TRIAL_LEN = SETTLE + 2;
`else
  localparam int TRIAL_LEN = SETTLE;
`endif
  // Counter only ever reaches TRIAL_LEN-1, so it never wraps.
  localparam int CNT_W = $clog2(TRIAL_LEN + 1);
  localparam int BIT_W = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] TRIAL_LAST  = CNT_W'(TRIAL_LEN - 1);
  localparam logic [BIT_W-1:0] MSB_IDX     = BIT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_CODE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_CODE   = {WIDTH{1'b0}};

  logic comp_s;

`ifdef DG_ADC_COMP_SYNC_EN
  dg_sync2 u_comp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (comp),
    .q     (comp_s)
  );
`else
  assign comp_s = comp;
`endif

  adc_state_e       state_r,  state_nxt_s;
  logic [CNT_W-1:0] cnt_r,    cnt_nxt_s;
  logic [BIT_W-1:0] bit_r,    bit_nxt_s;
  logic             fin_r,    fin_nxt_s;
  logic [WIDTH-1:0] dac_r,    dac_nxt_s;
  logic             sample_r, sample_nxt_s;
  logic             busy_r,   busy_nxt_s;
  logic             valid_r,  valid_nxt_s;
  logic [WIDTH-1:0] result_r, result_nxt_s;
  logic [WIDTH-1:0] bit_mask_s;
  logic [WIDTH-1:0] kept_s;

  // Decision for the bit under test: keep it on comp=1, clear it on comp=0.
  always_comb begin
    bit_mask_s = ONE_CODE << bit_r;
    if (comp_s) begin
      kept_s = dac_r;
    end else begin
      kept_s = dac_r & ~bit_mask_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    bit_nxt_s    = bit_r;
    fin_nxt_s    = fin_r;
    dac_nxt_s    = dac_r;
    sample_nxt_s = 1'b0;
    busy_nxt_s   = busy_r;
    valid_nxt_s  = valid_r;
    result_nxt_s = result_r;

    case (state_r)
      ST_IDLE: begin
        dac_nxt_s = ZERO_CODE;
        if (start) begin
          state_nxt_s  = ST_SAMPLE;
          cnt_nxt_s    = {CNT_W{1'b0}};
          sample_nxt_s = 1'b1;
          busy_nxt_s   = 1'b1;
        end else begin
          busy_nxt_s   = 1'b0;
        end
      end

      ST_SAMPLE: begin
        if (cnt_r == SAMPLE_LAST) begin
          state_nxt_s = ST_TRIAL;
          cnt_nxt_s   = {CNT_W{1'b0}};
          bit_nxt_s   = MSB_IDX;
          fin_nxt_s   = 1'b0;
          dac_nxt_s   = MSB_CODE;
        end else begin
          cnt_nxt_s    = cnt_r + CNT_W'(1);
          sample_nxt_s = 1'b1;
        end
      end

      ST_TRIAL: begin
        // fin_r marks the cycle after the LSB decision; the final code is
        // already on dac_r and is published here.
        if (fin_r) begin
          state_nxt_s  = ST_DONE;
          fin_nxt_s    = 1'b0;
          busy_nxt_s   = 1'b0;
          valid_nxt_s  = 1'b1;
          result_nxt_s = dac_r;
        end else if (cnt_r == TRIAL_LAST) begin
          cnt_nxt_s = {CNT_W{1'b0}};
          // Shifting the mask right sets the next lower trial bit; at the
          // LSB it shifts out to zero and the kept code is final.
          dac_nxt_s = kept_s | (bit_mask_s >> 1);
          if (bit_r == {BIT_W{1'b0}}) begin
            fin_nxt_s = 1'b1;
          end else begin
            bit_nxt_s = bit_r - BIT_W'(1);
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (valid_r && ready) begin
          valid_nxt_s = 1'b0;
          dac_nxt_s   = ZERO_CODE;
          cnt_nxt_s   = {CNT_W{1'b0}};
          if (start) begin
            state_nxt_s  = ST_SAMPLE;
            sample_nxt_s = 1'b1;
            busy_nxt_s   = 1'b1;
          end else begin
            state_nxt_s  = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_DONE;
        end
      end

      default: begin
        state_nxt_s  = ST_IDLE;
        cnt_nxt_s    = {CNT_W{1'b0}};
        bit_nxt_s    = {BIT_W{1'b0}};
        fin_nxt_s    = 1'b0;
        dac_nxt_s    = ZERO_CODE;
        busy_nxt_s   = 1'b0;
        valid_nxt_s  = 1'b0;
        result_nxt_s = ZERO_CODE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      bit_r    <= {BIT_W{1'b0}};
      fin_r    <= 1'b0;
      dac_r    <= ZERO_CODE;
      sample_r <= 1'b0;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      result_r <= ZERO_CODE;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      bit_r    <= bit_nxt_s;
      fin_r    <= fin_nxt_s;
      dac_r    <= dac_nxt_s;
      sample_r <= sample_nxt_s;
      busy_r   <= busy_nxt_s;
      valid_r  <= valid_nxt_s;
      result_r <= result_nxt_s;
    end
  end

  assign dac_code = dac_r;
  assign sample   = sample_r;
  assign busy     = busy_r;
  assign valid    = valid_r;
  assign result   = result_r;

endmodule

// File: tb/tb_dg_sar_adc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dg_sar_adc_ctrl
// Directed bench for dg_sar_adc_ctrl (WIDTH=8, SETTLE=2). A behavioural
// comparator (input level vs dac_code, or tied high/low) closes the loop.
// -----------------------------------------------------------------------------
module tb_dg_sar_adc_ctrl;

  localparam int SETTLE = 2;
`ifdef DG_ADC_COMP_SYNC_EN
  localparam int PH = SETTLE + 2;
`else
  localparam int PH = SETTLE;
`endif
  localparam int LAT = 1 + SETTLE + PH * 8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       comp;
  logic [7:0] dac_code;
  logic       sample;
  logic       busy;
  logic [7:0] result;
  logic       valid;
  logic       ready;

  int         mode;   // 0 = analog model, 1 = tied high, 2 = tied low
  logic [7:0] vin;

  int n_tests = 0;
  int n_fail  = 0;

  dg_sar_adc_ctrl #(.WIDTH(8), .SETTLE(SETTLE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .comp     (comp),
    .dac_code (dac_code),
    .sample   (sample),
    .busy     (busy),
    .result   (result),
    .valid    (valid),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic comp_model(input int m, input logic [7:0] v, input logic [7:0] t);
    if (m == 1) return 1'b1;
    if (m == 2) return 1'b0;
    return (v >= t);
  endfunction

  assign comp = comp_model(mode, vin, dac_code);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called just after the start-accepting edge; follows the conversion to valid.
  task automatic track(input int m, input logic [7:0] v, input logic [7:0] exp_res, input string tag);
    logic [7:0] seq [8];
    logic [7:0] code;
    logic [7:0] trial;
    int scnt;
    int lat;
    code = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      trial = code | (8'h01 << i);
      seq[7-i] = trial;
      if (comp_model(m, v, trial)) code = trial;
    end
    scnt = 0;
    lat  = -1;
    for (int n = 0; n < 80 && lat < 0; n++) begin
      @(negedge clk);
      if (n == 0) begin
        chk({tag, "_start"}, {29'd0, sample, busy, valid}, 32'd6);
      end
      if (sample) scnt++;
      if (n >= SETTLE && n < SETTLE + PH * 8 && ((n - SETTLE) % PH) == 0)
        chk($sformatf("%s_dac%0d", tag, (n - SETTLE) / PH), dac_code, seq[(n - SETTLE) / PH]);
      if (valid) lat = n;
    end
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_sample_cycles"}, scnt, SETTLE);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_busy_done"}, busy, 1'b0);
    chk({tag, "_dac_hold"}, dac_code, exp_res);
  endtask

  task automatic finish_hs(input string tag);
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, {22'd0, valid, busy, sample, dac_code}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    mode  = 0;
    vin   = 8'h00;
    #12;
    chk("rst_outputs", {14'd0, dac_code, sample, busy, valid, result}, 32'd0);

    // Start on the first edge after reset release, input 0xA5.
    vin = 8'hA5;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    track(0, 8'hA5, 8'hA5, "a5");
    finish_hs("a5");

    // Comparator tied high and low.
    mode = 1;
    launch();
    track(1, 8'h00, 8'hFF, "tie1");
    finish_hs("tie1");
    mode = 2;
    launch();
    track(2, 8'h00, 8'h00, "tie0");
    finish_hs("tie0");

    // Back-pressure: result holds and start is ignored while ready=0.
    mode = 0;
    vin  = 8'h5A;
    launch();
    track(0, 8'h5A, 8'h5A, "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), {22'd0, valid, sample, result}, {22'd0, 1'b1, 1'b0, 8'h5A});
      start = (i == 1 || i == 2);
    end
    @(negedge clk);
    start = 1'b0;
    chk("bp_ignored", {22'd0, valid, sample, result}, {22'd0, 1'b1, 1'b0, 8'h5A});
    // Handshake with start: next conversion begins immediately.
    vin   = 8'h33;
    ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    start = 1'b0;
    track(0, 8'h33, 8'h33, "b2b");
    finish_hs("b2b");

    // Asynchronous reset mid-conversion, then a fresh conversion.
    vin = 8'h55;
    launch();
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {14'd0, dac_code, sample, busy, valid, result}, 32'd0);
    vin = 8'h3C;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    track(0, 8'h3C, 8'h3C, "3c");
    finish_hs("3c");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dg_sar_adc_ctrl.md
DG_SAR_ADC_CTRL -- requirements
Module: dg_sar_adc_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, conversion resolution in bits (2..12).
REQ-002 SHALL have parameter SETTLE, default 2, cycles per sample phase and per bit trial (>=1).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, conversion request; accepted only as defined in REQ-012.
REQ-006 SHALL have port comp, input, 1, comparator output; 1 = analog input >= DAC output.
REQ-007 SHALL have port dac_code, output, WIDTH, trial code driving the capacitive/R-2R DAC.
REQ-008 SHALL have port sample, output, 1, track/hold control; high = track.
REQ-009 SHALL have port busy, output, 1, high from start acceptance until valid asserts.
REQ-010 SHALL have port result, output, WIDTH, converted code; stable while valid is high.
REQ-011 SHALL have ports valid (output, 1) and ready (input, 1), result handshake.

Function
REQ-012 SHALL accept start in IDLE, or in DONE in the same cycle that valid&&ready completes; start SHALL be ignored in all other states.
REQ-013 SHALL implement states IDLE, SAMPLE, TRIAL, DONE: IDLE->SAMPLE on accepted start; SAMPLE->TRIAL after SETTLE cycles; TRIAL loops over bits MSB to LSB; TRIAL->DONE after the LSB decision; DONE->IDLE on valid&&ready without start, DONE->SAMPLE on valid&&ready with start.
REQ-014 SHALL drive sample=1 only in SAMPLE, for exactly SETTLE cycles.
REQ-015 SHALL, per bit i in TRIAL, drive dac_code = kept upper bits | (1<<i), with lower bits 0, for SETTLE cycles. It SHALL sample comp on the last cycle of the phase. Bit i is kept if comp=1 and cleared if comp=0.
REQ-016 SHALL assert valid, with result = final code, exactly 1+SETTLE*(WIDTH+1) cycles after the start-accepting edge.
REQ-017 SHALL hold valid and result unchanged while ready=0. valid SHALL drop the cycle after valid&&ready unless a new conversion completes.
REQ-018 SHALL drive dac_code=0 in IDLE, hold the final code in DONE, and drive busy=1 in SAMPLE and TRIAL only.
REQ-019 SHALL use an internal cycle counter of width clog2(SETTLE+1) and a bit index of width clog2(WIDTH). Neither SHALL wrap in a way that is visible outside the block.

Reset
REQ-020 SHALL, on rst_n low at any time including mid-conversion, immediately force state IDLE, dac_code=0, sample=0, busy=0, valid=0, result=0, and clear all counters.
REQ-021 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-022 SHALL, with macro DG_ADC_COMP_SYNC_EN defined, pass comp through a 2-flop synchronizer and extend each TRIAL bit phase to SETTLE+2 cycles. Valid latency then becomes 1+SETTLE+(SETTLE+2)*WIDTH.
REQ-023 SHALL, without DG_ADC_COMP_SYNC_EN, use comp directly with the timing of REQ-016.

Structure
REQ-024 SHALL place the state enum and the default WIDTH/SETTLE constants in shared package dg_adc_pkg.
REQ-025 SHALL implement the synchronizer as sub-module dg_sync2, instantiated only under DG_ADC_COMP_SYNC_EN.

Verification (WIDTH=8, SETTLE=2 unless stated)
REQ-026 SHALL cover the following case: comparator model with input 0xA5 and start pulse at edge k -> sample high for 2 cycles, dac_code sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5, valid at k+19 with result=0xA5.
REQ-027 SHALL cover the following case: comp tied 1 -> result 0xFF; comp tied 0 -> result 0x00. Both at k+19.
REQ-028 SHALL cover the following case: ready held 0 for 5 cycles after valid, with start pulsed during that time -> valid and result stay constant and start is ignored. Then ready=1 with start=1 -> valid drops and sample rises next cycle.
REQ-029 SHALL cover the following case: rst_n pulsed low at cycle k+9 mid-conversion -> all outputs 0 asynchronously, and a fresh conversion of input 0x3C yields 0x3C at 19 cycles after its start.
REQ-030 SHALL cover the following case: with DG_ADC_COMP_SYNC_EN defined and input 0xA5 -> result 0xA5 at k+35, each dac_code trial lasting 4 cycles.
